mux_dot_seq: RTL and testbench



---
 rtl/mux_dot_seq_if.sv | 38 +++
 rtl/mux_dot_seq.sv | 136 +++++++++++++
 tb/tb_mux_dot_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_dot_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_dot_seq_if
// Purpose  : Operand/result bus between the dot-product sequencer, its
//            upstream/downstream, and the external N-way word selector.
// Revision : 1.0
// ============================================================================
interface mux_dot_seq_if #(
  parameter int N      = 2,
  parameter int DATA_W = 32
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W*N-1:0]   a_in;
  logic [DATA_W*N-1:0]   coef_in;
  logic [DATA_W*N-1:0]   a_q;
  logic [SEL_W-1:0]      sel;
  logic [DATA_W-1:0]     mux_s;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     dot_out;
  logic                  sat;

  // Environment side: upstream source, downstream sink and the selector.
  modport master (
    output in_valid, a_in, coef_in, mux_s, out_ready,
    input  in_ready, a_q, sel, out_valid, dot_out, sat
  );

  // Sequencer side.
  modport slave (
    input  in_valid, a_in, coef_in, mux_s, out_ready,
    output in_ready, a_q, sel, out_valid, dot_out, sat
  );
endinterface
`default_nettype wire

// File: rtl/mux_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : mux_dot_seq
// Purpose  : Walks an external word selector over N lanes and accumulates a
//            saturated signed fixed-point dot product per transaction.
// Revision : 1.0
// ============================================================================
module mux_dot_seq #(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_dot_seq_if.slave bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2*DATA_W + SEL_W + 1;
  localparam int EXT_W = ACC_W - 2*DATA_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q;
  logic [SEL_W-1:0]          sel_q;
  logic [DATA_W*N-1:0]       a_q;
  logic [DATA_W*N-1:0]       coef_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [DATA_W-1:0]         dot_q;
  logic                      sat_q;
  logic                      in_ready_q;
  logic                      out_valid_q;

  logic [DATA_W-1:0]         coef_lane;
  logic signed [2*DATA_W-1:0] mux_ext;
  logic signed [2*DATA_W-1:0] coef_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         dot_d;
  logic                      sat_d;

  // Next accumulator value and the clamped result it would produce; the
  // result is only captured on the last RUN cycle, so the final product
  // is always included.
  always_comb begin
    coef_lane = coef_q[int'(sel_q)*DATA_W +: DATA_W];
    mux_ext   = {{DATA_W{bus.mux_s[DATA_W-1]}}, bus.mux_s};
    coef_ext  = {{DATA_W{coef_lane[DATA_W-1]}}, coef_lane};
    prod      = mux_ext * coef_ext;
    acc_d     = acc_q + {{EXT_W{prod[2*DATA_W-1]}}, prod};
    shifted   = acc_d >>> FRAC_W;
    dot_d     = shifted[DATA_W-1:0];
    sat_d     = 1'b0;
    if (shifted > ACC_MAX) begin
      dot_d = OUT_MAX;
      sat_d = 1'b1;
    end else if (shifted < ACC_MIN) begin
      dot_d = OUT_MIN;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      a_q         <= '0;
      coef_q      <= '0;
      acc_q       <= '0;
      dot_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a_in;
            coef_q     <= bus.coef_in;
            sel_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (sel_q == SEL_LAST) begin
            dot_q       <= dot_d;
            sat_q       <= sat_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end
        S_DONE: begin
          // sel parks at 0 while idle so the selector sees lane 0 between jobs.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sel_q       <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          sel_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a_q       = a_q;
  assign bus.sel       = sel_q;
  assign bus.dot_out   = dot_q;
  assign bus.sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_dot_seq
// Purpose  : Directed scoreboard bench for mux_dot_seq at N=4 and N=1.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mux_dot_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mux_dot_seq_if #(.N(4), .DATA_W(16)) bus4 ();
  mux_dot_seq_if #(.N(1), .DATA_W(16)) bus1 ();

  // External selectors.
  assign bus4.mux_s = bus4.a_q[int'(bus4.sel)*16 +: 16];
  assign bus1.mux_s = bus1.a_q[15:0];

  mux_dot_seq #(.N(4), .DATA_W(16), .FRAC_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );
  mux_dot_seq #(.N(1), .DATA_W(16), .FRAC_W(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [15:0] q4_dot[$];
  bit          q4_sat[$];
  logic [15:0] q1_dot[$];
  bit          q1_sat[$];

  function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare at each output handshake.
  always @(negedge clk) begin
    logic [15:0] ed;
    bit          es;
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (q4_dot.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut4_unexpected_result: got dot 0x%0h expected none", bus4.dot_out);
      end else begin
        ed = q4_dot.pop_front();
        es = q4_sat.pop_front();
        chk("dut4_dot", 64'(bus4.dot_out), 64'(ed));
        chk("dut4_sat", 64'(bus4.sat), 64'(es));
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] ed;
    bit          es;
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      if (q1_dot.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_result: got dot 0x%0h expected none", bus1.dot_out);
      end else begin
        ed = q1_dot.pop_front();
        es = q1_sat.pop_front();
        chk("dut1_dot", 64'(bus1.dot_out), 64'(ed));
        chk("dut1_sat", 64'(bus1.sat), 64'(es));
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input bit which, input logic [63:0] a, input logic [63:0] c,
                      input bit push, input logic [15:0] ed, input bit es,
                      output int acc_cyc);
    int  waited;
    logic rdy;
    waited = 0;
    if (which) begin
      bus1.in_valid = 1'b1; bus1.a_in = a[15:0]; bus1.coef_in = c[15:0];
      if (push) begin q1_dot.push_back(ed); q1_sat.push_back(es); end
    end else begin
      bus4.in_valid = 1'b1; bus4.a_in = a; bus4.coef_in = c;
      if (push) begin q4_dot.push_back(ed); q4_sat.push_back(es); end
    end
    forever begin
      @(negedge clk);
      rdy = which ? bus1.in_ready : bus4.in_ready;
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    if (which) bus1.in_valid = 1'b0;
    else       bus4.in_valid = 1'b0;
  endtask

  // Returns at a negedge where out_valid is high (or after timeout).
  task automatic wait_valid(input bit which);
    int  waited;
    logic v;
    waited = 0;
    forever begin
      @(negedge clk);
      v = which ? bus1.out_valid : bus4.out_valid;
      if (v) break;
      waited++;
      if (waited > 50) begin
        checks++;
        failures++;
        $display("FAIL valid_timeout: got out_valid 0 expected 1 within 50 cycles");
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.a_in = '0; bus4.coef_in = '0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a_in = '0; bus1.coef_in = '0; bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready",  64'(bus4.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    chk("rst_sel",       64'(bus4.sel), 64'd0);
    chk("rst_dot",       64'(bus4.dot_out), 64'd0);
    chk("rst_sat",       64'(bus4.sat), 64'd0);
    chk("rst_a_q",       bus4.a_q, 64'd0);
    chk("rst1_in_ready", 64'(bus1.in_ready), 64'd1);
    @(posedge clk); #1;

    // Basic dot product with sel walk and latency.
    send(1'b0, pack4(256, 512, -256, 128), pack4(256, 256, 256, 512), 1'b1, 16'd768, 1'b0, t1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("run_sel_%0d", k), 64'(bus4.sel), 64'(k));
      chk($sformatf("run_nvalid_%0d", k), 64'(bus4.out_valid), 64'd0);
    end
    @(negedge clk);
    chk("basic_latency_valid", 64'(bus4.out_valid), 64'd1);
    @(posedge clk); #1;

    // Saturation both directions and floor rounding.
    send(1'b0, pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767),
         1'b1, 16'h7FFF, 1'b1, t1);
    wait_valid(1'b0); @(posedge clk); #1;
    send(1'b0, pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767),
         1'b1, 16'h8000, 1'b1, t1);
    wait_valid(1'b0); @(posedge clk); #1;
    send(1'b0, pack4(-1, 0, 0, 0), pack4(1, 0, 0, 0), 1'b1, 16'hFFFF, 1'b0, t1);
    wait_valid(1'b0); @(posedge clk); #1;

    // Backpressure in DONE with an ignored in_valid pulse.
    bus4.out_ready = 1'b0;
    send(1'b0, pack4(100, 200, 300, 400), pack4(256, 256, 256, 256), 1'b1, 16'd1000, 1'b0, t1);
    wait_valid(1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), 64'(bus4.out_valid), 64'd1);
      chk($sformatf("bp_dot_%0d", i), 64'(bus4.dot_out), 64'd1000);
      chk($sformatf("bp_in_ready_%0d", i), 64'(bus4.in_ready), 64'd0);
      if (i == 2) begin
        bus4.in_valid = 1'b1;
        bus4.a_in = pack4(32767, 32767, 32767, 32767);
        bus4.coef_in = pack4(32767, 32767, 32767, 32767);
      end
      if (i == 3) bus4.in_valid = 1'b0;
    end
    @(posedge clk); #1 bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(bus4.in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(bus4.out_valid), 64'd0);
    chk("bp_dot_hold", 64'(bus4.dot_out), 64'd1000);
    @(posedge clk); #1;

    // Reset in the middle of RUN: dropped with no output.
    send(1'b0, pack4(256, 512, -256, 128), pack4(256, 256, 256, 512), 1'b0, 16'd0, 1'b0, t1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_sel_before", 64'(bus4.sel), 64'd2);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("midrst_sel", 64'(bus4.sel), 64'd0);
    chk("midrst_out_valid", 64'(bus4.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus4.in_ready), 64'd1);
    send(1'b0, pack4(256, 512, -256, 128), pack4(256, 256, 256, 512), 1'b1, 16'd768, 1'b0, t1);
    wait_valid(1'b0); @(posedge clk); #1;

    // Back-to-back with out_ready held high.
    send(1'b0, pack4(768, 0, 0, -256), pack4(256, 0, 0, 256), 1'b1, 16'd512, 1'b0, t1);
    send(1'b0, pack4(-300, 0, 0, 0), pack4(256, 0, 0, 0), 1'b1, 16'hFED4, 1'b0, t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'd6);
    wait_valid(1'b0); @(posedge clk); #1;

    // Single lane.
    send(1'b1, 64'd384, 64'd512, 1'b1, 16'd768, 1'b0, t1);
    @(negedge clk);
    chk("n1_run_sel", 64'(bus1.sel), 64'd0);
    chk("n1_run_nvalid", 64'(bus1.out_valid), 64'd0);
    @(negedge clk);
    chk("n1_valid", 64'(bus1.out_valid), 64'd1);
    chk("n1_done_sel", 64'(bus1.sel), 64'd0);
    @(posedge clk); #1;

    // Drain the scoreboards.
    for (int i = 0; i < 20; i++) begin
      if (q4_dot.size() == 0 && q1_dot.size() == 0) break;
      @(posedge clk);
    end
    if (q4_dot.size() != 0 || q1_dot.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d/%0d pending results expected 0/0", q4_dot.size(), q1_dot.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
